// File: rtl/multdiv_ctrl.sv
// Multiply/divide sequencer for the execute stage: fixed-latency multiply,
// 32-cycle restoring divide with a sign-fix cycle, and HI/LO result registers.
module multdiv_ctrl #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        advance,
  output logic        ok,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_LATENCY - 1);

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] a_q, b_q;
  logic        sgn_q;
  logic [31:0] quo, rem;

  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted;
  logic        q_bit;
  logic [31:0] rem_nxt;
  logic [63:0] prod;
  logic [31:0] q_fix, r_fix;

  always_comb begin
    a_mag   = (!op[0] && a[31]) ? -a : a;
    b_mag   = (sgn_q && b_q[31]) ? -b_q : b_q;
    // Dividend bits shift out of the top of quo while quotient bits enter at the bottom.
    shifted = {rem, quo[31]};
    q_bit   = (shifted >= {1'b0, b_mag});
    rem_nxt = q_bit ? 32'(shifted - {1'b0, b_mag}) : shifted[31:0];
    prod    = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
    if (b_q == '0) begin
      q_fix = '1;
      r_fix = a_q;
    end else begin
      q_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? -quo : quo;
      r_fix = (sgn_q && a_q[31]) ? -rem : rem;
    end
  end

  assign ok = (state == DONE) || ((state == IDLE) && !valid);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      quo   <= '0;
      rem   <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          a_q   <= a;
          b_q   <= b;
          sgn_q <= ~op[0];
          cnt   <= '0;
          quo   <= a_mag;
          rem   <= '0;
          busy  <= 1'b1;
          state <= op[1] ? DIV : MUL;
        end
        MUL: if (cnt == MUL_LAST) begin
          {hi, lo} <= prod;
          busy     <= 1'b0;
          state    <= DONE;
        end else begin
          cnt <= cnt + 5'd1;
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= {quo[30:0], q_bit};
          if (cnt == 5'd31) state <= FIX;
          else              cnt   <= cnt + 5'd1;
        end
        FIX: begin
          lo    <= q_fix;
          hi    <= r_fix;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: if (advance) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: latency, results, hold, flush and reset behaviour.
module tb_multdiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        advance = 1'b0;
  logic        ok, busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail = 0;

  multdiv_ctrl #(.MUL_LATENCY(3)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .a(a), .b(b),
    .flush(flush), .advance(advance), .ok(ok), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait for ok; the accept edge counts as cycle 1.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    valid = 1'b1; op = o; a = x; b = y;
    #1;
    check({tag, " ok_pre"}, ok, 1'b0);
    tick();
    valid = 1'b0; a = ~x; b = y ^ 32'h5A5A_5A5A;
    check({tag, " busy"}, busy, 1'b1);
    n = 1;
    while (!ok && n < 100) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
  endtask

  task automatic retire(input string tag);
    advance = 1'b1;
    tick();
    advance = 1'b0;
    check({tag, " idle_busy"}, busy, 1'b0);
    check({tag, " idle_ok"}, ok, 1'b1);
  endtask

  initial begin
    #2;
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);
    check("rst busy", busy, 1'b0);
    check("rst ok", ok, 1'b1);
    tick();
    resetn = 1'b1;
    tick();

    run_op("mult", 2'd0, 32'hFFFF_FFFF, 32'd2, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    retire("mult");
    run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'd2, 4, 32'h0000_0001, 32'hFFFF_FFFE);
    retire("multu");
    run_op("mult_nn", 2'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 4, 32'h0, 32'h0000_000F);
    retire("mult_nn");
    run_op("div_m7", 2'd2, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    retire("div_m7");
    run_op("div_7m2", 2'd2, 32'd7, 32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD);
    retire("div_7m2");
    run_op("divu", 2'd3, 32'd100, 32'd7, 34, 32'h0000_0002, 32'h0000_000E);
    retire("divu");
    run_op("divu_z", 2'd3, 32'h1234_5678, 32'd0, 34, 32'h1234_5678, 32'hFFFF_FFFF);
    retire("divu_z");
    run_op("div_z", 2'd2, 32'h1234_5678, 32'd0, 34, 32'h1234_5678, 32'hFFFF_FFFF);
    retire("div_z");
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);

    // Hold in DONE with a pending request: no re-accept, results stable.
    valid = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold ok", ok, 1'b1);
      check("hold busy", busy, 1'b0);
      check("hold hilo", {hi, lo}, {32'h0, 32'h8000_0000});
    end
    advance = 1'b1;
    tick();
    advance = 1'b0;
    valid = 1'b0;
    check("adv_noaccept busy", busy, 1'b0);
    tick();
    check("adv_idle busy", busy, 1'b0);
    check("adv_idle ok", ok, 1'b1);

    // Flush mid-divide.
    valid = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd3;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("flush pre busy", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", busy, 1'b0);
    check("flush ok", ok, 1'b1);
    check("flush hilo", {hi, lo}, {32'h0, 32'h8000_0000});
    tick();
    tick();
    check("flush stay busy", busy, 1'b0);
    run_op("multu35", 2'd1, 32'd3, 32'd5, 4, 32'h0, 32'h0000_000F);
    retire("multu35");

    // Reset mid-multiply.
    valid = 1'b1; op = 2'd0; a = 32'd7; b = 32'd6;
    tick();
    valid = 1'b0;
    tick();
    check("midrst pre busy", busy, 1'b1);
    resetn = 1'b0;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst hilo", {hi, lo}, 64'h0);
    check("midrst ok", ok, 1'b1);
    tick();
    resetn = 1'b1;
    run_op("post_rst", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFE, 32'h0000_0001);
    retire("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 3, legal 1..8: number of MUL-state cycles a multiply occupies.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valid  input  1  execute stage holds a mult/div instruction.
REQ-005 SHALL have port op  input  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 SHALL have port a  input  32  operand rs (multiplicand / dividend).
REQ-007 SHALL have port b  input  32  operand rt (multiplier / divisor).
REQ-008 SHALL have port flush  input  1  abort the current operation; nothing is committed.
REQ-009 SHALL have port advance  input  1  execute stage moves on this cycle; consumes the result.
REQ-010 SHALL have port ok  output  1  result available, or no operation needed; hazard unit stalls while 0.
REQ-011 SHALL have port busy  output  1  operation in progress (MUL, DIV or FIX state).
REQ-012 SHALL have port hi  output  32  result register HI.
REQ-013 SHALL have port lo  output  32  result register LO.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, FIX, DONE.
REQ-015 IDLE SHALL accept when valid=1 and flush=0: latch a, b, op; ops 0/1 go to MUL, ops 2/3 go to DIV; counter cleared.
REQ-016 MUL SHALL stay MUL_LATENCY cycles, then load {hi,lo} = 64-bit product (op 0 signed x signed, op 1 unsigned) and go to DONE.
REQ-017 DIV SHALL run a 32-iteration restoring division on operand magnitudes, one quotient bit per cycle, counter 0..31, then go to FIX.
REQ-018 FIX SHALL apply signs for op 2 (quotient negated iff operand signs differ; remainder takes the dividend's sign), load lo=quotient and hi=remainder, and go to DONE; op 3 SHALL apply no sign fix.
REQ-019 Divide by zero (b=0) SHALL still take the full DIV+FIX timing and produce lo=32'hFFFF_FFFF, hi=a for both op 2 and op 3.
REQ-020 Signed 32'h8000_0000 / 32'hFFFF_FFFF SHALL produce lo=32'h8000_0000, hi=0.
REQ-021 DONE SHALL hold until advance=1, then return to IDLE; no new accept SHALL occur in that same cycle.
REQ-022 ok SHALL be combinational: 1 in DONE, 1 in IDLE when valid=0, 0 otherwise.
REQ-023 Latency from the accept edge to ok=1 SHALL be MUL_LATENCY+1 cycles for a multiply and 34 cycles for a divide.
REQ-024 flush=1 in any state SHALL force IDLE at the next edge, leave hi/lo unchanged, and take priority over accept and advance.
REQ-025 hi/lo SHALL change only on the MUL->DONE or FIX->DONE transition; operand changes on a/b after accept SHALL have no effect.
REQ-026 busy SHALL be 1 exactly in MUL, DIV and FIX.

Reset
REQ-027 resetn=0 SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, busy=0, and clear the latched operands; ok then follows REQ-022.
REQ-028 Reset during MUL or DIV SHALL discard the operation; the first edge after resetn=1 SHALL be able to accept a new request.

Verification
REQ-029 MULT a=FFFFFFFF, b=2, MUL_LATENCY=3 -> ok=1 four cycles after accept; hi=FFFFFFFF, lo=FFFFFFFE; MULTU with the same operands -> hi=00000001, lo=FFFFFFFE.
REQ-030 DIV a=FFFFFFF9 (-7), b=2 -> ok=1 at cycle 34; lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=100, b=7 -> lo=0000000E, hi=00000002.
REQ-031 DIVU and DIV with b=0, a=12345678 -> lo=FFFFFFFF, hi=12345678 at cycle 34; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-032 DONE with advance=0 held 5 cycles -> ok stays 1, hi/lo stable, no re-accept; advance=1 -> IDLE next cycle.
REQ-033 flush at DIV cycle 10 -> IDLE next edge, hi/lo keep prior values; new MULTU 3x5 then accepted -> lo=0000000F, hi=0.
REQ-034 resetn pulsed low mid-MUL -> immediate IDLE, hi=lo=0, busy=0; a request after release completes normally.
